// File: rtl/stat_seq_pkg.sv
// Shared types and helpers for the stat_seq synthetic benchmark core.
package stat_seq_pkg;

    typedef enum logic [2:0] {
        G_AND, G_NAND, G_OR, G_NOR, G_XOR, G_XNOR, G_BUF, G_NOT
    } gate_e;

    localparam int TAP_B = 1;   // plus the layer index
    localparam int TAP_C = 3;
    localparam int TAP_D = 7;

    // taps[0] is the bit's own input; BUF/NOT look at nothing else
    function automatic logic gate_eval(gate_e g, logic [3:0] taps);
        case (g)
            G_AND:   return &taps;
            G_NAND:  return ~&taps;
            G_OR:    return |taps;
            G_NOR:   return ~|taps;
            G_XOR:   return ^taps;
            G_XNOR:  return ~^taps;
            G_BUF:   return taps[0];
            default: return ~taps[0];
        endcase
    endfunction

    function automatic gate_e gate_sel(int bit_idx, int layer_idx);
        return gate_e'(3'((bit_idx + layer_idx) % 8));
    endfunction

    function automatic int lw_calc(int n_in, int n_state);
        return n_in + n_state;
    endfunction

    function automatic int latency_calc(int n_layers, int pipe_en);
        return (pipe_en != 0) ? n_layers + 1 : 2;
    endfunction

endpackage

// File: rtl/stat_seq_layer.sv
// One combinational gate layer; gate type and tap pattern fixed by bit and layer index.
module stat_seq_layer
    import stat_seq_pkg::*;
#(
    parameter int LW        = 28,
    parameter int LAYER_IDX = 0
) (
    input  logic [LW-1:0] a_i,
    output logic [LW-1:0] y_o
);

    for (genvar i = 0; i < LW; i++) begin : g_bit
        localparam gate_e G = gate_sel(i, LAYER_IDX);
        logic [3:0] taps;
        assign taps   = {a_i[(i + TAP_D) % LW], a_i[(i + TAP_C) % LW],
                         a_i[(i + TAP_B + LAYER_IDX) % LW], a_i[i]};
        assign y_o[i] = gate_eval(G, taps);
    end

endmodule

// File: rtl/stat_seq_pipe.sv
// Sequential synthetic benchmark core: layered gate pipeline with state feedback,
// valid/ready handshake, MISR signature and saturating beat counter.
module stat_seq_pipe
    import stat_seq_pkg::*;
#(
    parameter int               N_IN      = 20,
    parameter int               N_OUT     = 24,
    parameter int               N_STATE   = 8,
    parameter int               N_LAYERS  = 3,
    parameter int               PIPE_EN   = 1,
    parameter logic [N_OUT-1:0] MISR_POLY = 'h1B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             sig_clr,
    output logic [N_OUT-1:0] signature,
    output logic [15:0]      beat_cnt
);

    localparam int LW   = lw_calc(N_IN, N_STATE);
    localparam int NSTG = latency_calc(N_LAYERS, PIPE_EN) - 1;  // index of the output register
    localparam int SW   = (N_STATE > 0) ? N_STATE : 1;

    logic [NSTG:0][LW-1:0]     stg_q, stg_d;
    logic [NSTG:0]             vld_pipe_q;
    logic [N_LAYERS-1:0][LW-1:0] lin, lout;
    logic [LW-1:0]             a_d;
    logic [SW-1:0]             state_q;
    logic [N_OUT-1:0]          sig_q, sig_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      adv, acc;

    assign out_valid = vld_pipe_q[NSTG];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign acc       = out_valid && out_ready;
    assign out_data  = stg_q[NSTG][N_OUT-1:0];
    assign signature = sig_q;
    assign beat_cnt  = cnt_q;

    // Unpipelined: layers chain combinationally from stage 0 into the single output register
    for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
        if (PIPE_EN != 0 || l == 0) begin : g_from_reg
            assign lin[l] = stg_q[l];
        end else begin : g_from_comb
            assign lin[l] = lout[l-1];
        end
        stat_seq_layer #(.LW(LW), .LAYER_IDX(l)) u_layer (.a_i(lin[l]), .y_o(lout[l]));
    end

    assign stg_d[0] = a_d;
    for (genvar k = 1; k <= NSTG; k++) begin : g_stg
        assign stg_d[k] = lout[(PIPE_EN != 0) ? k - 1 : N_LAYERS - 1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q      <= '0;
            vld_pipe_q <= '0;
        end else if (adv) begin
            stg_q      <= stg_d;
            vld_pipe_q <= {vld_pipe_q[NSTG-1:0], in_valid};
        end
    end

    // Stage 0 samples state_q before this cycle's accept updates it
    if (N_STATE > 0) begin : g_state
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      state_q <= '0;
            else if (acc) state_q <= stg_q[NSTG][LW-1 -: N_STATE];
        end
        assign a_d = {state_q, in_data};
    end else begin : g_nostate
        assign state_q = '0;
        assign a_d     = in_data;
    end

    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clr) begin
            sig_d = '0;
            cnt_d = '0;
        end else if (acc) begin
            sig_d = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? MISR_POLY : '0) ^ out_data;
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
            cnt_q <= '0;
        end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stat_seq_pipe.sv
// Directed bench for stat_seq_pipe: tiny config, default pipelined and unpipelined configs.
module tb_stat_seq_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, sig_clr = 1'b0;
    logic [19:0] in_data = '0;
    logic        d_in_ready, d_out_valid, n_in_ready, n_out_valid;
    logic [23:0] d_out_data, d_sig, n_out_data, n_sig;
    logic [15:0] d_cnt, n_cnt;
    logic        s_in_valid = 1'b0, s_out_ready = 1'b1, s_sig_clr = 1'b0;
    logic [3:0]  s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_out_data, s_sig;
    logic [15:0] s_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stat_seq_pipe u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
        .sig_clr(sig_clr), .signature(d_sig), .beat_cnt(d_cnt));

    stat_seq_pipe #(.PIPE_EN(0)) u_np (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .sig_clr(sig_clr), .signature(n_sig), .beat_cnt(n_cnt));

    stat_seq_pipe #(.N_IN(4), .N_OUT(4), .N_STATE(0), .N_LAYERS(1), .PIPE_EN(1), .MISR_POLY(4'h3)) u_sm (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .sig_clr(s_sig_clr), .signature(s_sig), .beat_cnt(s_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: 3 layers over LW=28, a = {state[7:0], in[19:0]}
    function automatic logic [27:0] m_final(logic [7:0] st, logic [19:0] din);
        logic [27:0] a, y;
        logic [3:0]  t;
        a = {st, din};
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 28; i++) begin
                t = {a[(i + 7) % 28], a[(i + 3) % 28], a[(i + 1 + l) % 28], a[i]};
                case ((i + l) % 8)
                    0: y[i] = &t;
                    1: y[i] = ~&t;
                    2: y[i] = |t;
                    3: y[i] = ~|t;
                    4: y[i] = ^t;
                    5: y[i] = ~^t;
                    6: y[i] = a[i];
                    default: y[i] = ~a[i];
                endcase
            end
            a = y;
        end
        return a;
    endfunction

    function automatic logic [23:0] m_misr(logic [23:0] s, logic [23:0] d);
        return {s[22:0], 1'b0} ^ (s[23] ? 24'h1B : 24'h0) ^ d;
    endfunction

    logic [19:0] vec [100];
    logic [27:0] fin [100];
    logic [27:0] nfin[100];
    logic [19:0] bp  [5];
    logic [27:0] e_exp, c_exp, c_prev;
    logic [23:0] m_sig, mn_sig, npd;

    initial begin
        // ---- reset state
        step();
        chk("rst_ovld", {31'b0, d_out_valid}, 0);
        chk("rst_odata", {8'b0, d_out_data}, 0);
        chk("rst_sig", {8'b0, d_sig}, 0);
        chk("rst_cnt", {16'b0, d_cnt}, 0);
        chk("rst_state", {24'b0, u_def.state_q}, 0);
        rst = 1'b0;
        #1 chk("rst_irdy", {31'b0, d_in_ready}, 1);

        // ---- tiny config: F -> 5, 0 -> A, two cycles after accept
        step(); s_in_valid = 1'b1; s_in_data = 4'hF;
        step(); chk("sm_vld_c1", {31'b0, s_out_valid}, 0); s_in_data = 4'h0;
        step(); chk("sm_vld_c2", {31'b0, s_out_valid}, 1);
        chk("sm_F", {28'b0, s_out_data}, 32'h5); s_in_valid = 1'b0;
        step(); chk("sm_vld_c3", {31'b0, s_out_valid}, 1);
        chk("sm_0", {28'b0, s_out_data}, 32'hA);
        step(); chk("sm_vld_c4", {31'b0, s_out_valid}, 0);

        // ---- 100 back-to-back beats; pipelined L=4, unpipelined L=2
        for (int b = 0; b < 100; b++) vec[b] = 20'($urandom);
        m_sig = '0; mn_sig = '0;
        for (int b = 0; b < 100; b++) begin
            fin[b]  = m_final((b >= 5) ? fin[b-5][27:20]  : 8'h0, vec[b]);
            nfin[b] = m_final((b >= 3) ? nfin[b-3][27:20] : 8'h0, vec[b]);
            m_sig   = m_misr(m_sig, fin[b][23:0]);
            mn_sig  = m_misr(mn_sig, nfin[b][23:0]);
        end
        for (int c = 0; c < 104; c++) begin
            step();
            if (c >= 4) begin
                chk("b2b_vld", {31'b0, d_out_valid}, 1);
                chk("b2b_data", {8'b0, d_out_data}, {8'b0, fin[c-4][23:0]});
            end else begin
                chk("b2b_vld_early", {31'b0, d_out_valid}, 0);
            end
            if (c >= 2 && c < 102) begin
                chk("np_vld", {31'b0, n_out_valid}, 1);
                chk("np_data", {8'b0, n_out_data}, {8'b0, nfin[c-2][23:0]});
            end
            in_valid = (c < 100);
            in_data  = (c < 100) ? vec[c] : 20'h0;
        end
        step();
        chk("b2b_drain", {31'b0, d_out_valid}, 0);
        chk("b2b_cnt", {16'b0, d_cnt}, 100);
        chk("b2b_sig", {8'b0, d_sig}, {8'b0, m_sig});
        chk("b2b_state", {24'b0, u_def.state_q}, {24'b0, fin[99][27:20]});
        chk("np_cnt", {16'b0, n_cnt}, 100);
        chk("np_sig", {8'b0, n_sig}, {8'b0, mn_sig});

        // ---- reset with 3 beats in flight
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = vec[c]; step();
        end
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mrst_ovld", {31'b0, d_out_valid}, 0);
        chk("mrst_sig", {8'b0, d_sig}, 0);
        chk("mrst_cnt", {16'b0, d_cnt}, 0);
        step(); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(); chk("mrst_stale", {31'b0, d_out_valid}, 0);
        end

        // ---- backpressure: fill 4 stages, stall 5 cycles, drain
        bp[0] = 20'h12345; bp[1] = 20'hFEDCB; bp[2] = 20'h00F0F; bp[3] = 20'hA5A5A; bp[4] = 20'h33333;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = bp[c]; step();
        end
        in_data = bp[4];
        for (int c = 0; c < 5; c++) begin
            chk("bp_irdy", {31'b0, d_in_ready}, 0);
            chk("bp_vld", {31'b0, d_out_valid}, 1);
            chk("bp_hold", {8'b0, d_out_data}, {8'b0, m_final(8'h0, bp[0])[23:0]});
            chk("bp_sig", {8'b0, d_sig}, 0);
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        m_sig = '0;
        for (int c = 0; c < 4; c++) begin
            chk("bp_dvld", {31'b0, d_out_valid}, 1);
            chk("bp_ddata", {8'b0, d_out_data}, {8'b0, m_final(8'h0, bp[c])[23:0]});
            m_sig = m_misr(m_sig, m_final(8'h0, bp[c])[23:0]);
            step();
        end
        chk("bp_nodup", {31'b0, d_out_valid}, 0);
        chk("bp_cnt", {16'b0, d_cnt}, 4);
        chk("bp_sigf", {8'b0, d_sig}, {8'b0, m_sig});

        // ---- sig_clr coincident with an accept
        e_exp = m_final(m_final(8'h0, bp[3])[27:20], 20'hABCDE);
        in_valid = 1'b1; in_data = 20'hABCDE;
        step(); in_valid = 1'b0;
        step(); step(); step();
        chk("clr_vld", {31'b0, d_out_valid}, 1);
        chk("clr_data", {8'b0, d_out_data}, {8'b0, e_exp[23:0]});
        chk("clr_cnt_pre", {16'b0, d_cnt}, 4);
        sig_clr = 1'b1;
        step(); sig_clr = 1'b0;
        chk("clr_sig", {8'b0, d_sig}, 0);
        chk("clr_cnt", {16'b0, d_cnt}, 0);
        chk("clr_state", {24'b0, u_def.state_q}, {24'b0, e_exp[27:20]});

        // ---- spaced beats: PIPE_EN=0 and =1 must agree bit for bit
        rst = 1'b1; step(); rst = 1'b0;
        c_prev = '0; m_sig = '0;
        for (int k = 0; k < 6; k++) begin
            c_exp = m_final(c_prev[27:20], vec[10 + k]);
            m_sig = m_misr(m_sig, c_exp[23:0]);
            step(); in_valid = 1'b1; in_data = vec[10 + k];
            step(); in_valid = 1'b0;
            chk("sp_np_early", {31'b0, n_out_valid}, 0);
            step();
            chk("sp_np_vld", {31'b0, n_out_valid}, 1);
            chk("sp_np_data", {8'b0, n_out_data}, {8'b0, c_exp[23:0]});
            npd = n_out_data;
            step();
            chk("sp_def_early", {31'b0, d_out_valid}, 0);
            step();
            chk("sp_def_vld", {31'b0, d_out_valid}, 1);
            chk("sp_def_data", {8'b0, d_out_data}, {8'b0, c_exp[23:0]});
            chk("sp_same", {8'b0, d_out_data}, {8'b0, npd});
            c_prev = c_exp;
        end
        step();
        chk("sp_np_sig", {8'b0, n_sig}, {8'b0, m_sig});
        chk("sp_def_sig", {8'b0, d_sig}, {8'b0, m_sig});
        chk("sp_np_state", {24'b0, u_np.state_q}, {24'b0, c_prev[27:20]});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
